// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the pulse stretcher.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Down-counter width: must hold the larger of HOLD-1 and GAP-1.
  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
    int unsigned m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

  function automatic int unsigned pend_width(input int unsigned max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event input and stretched-level outputs of the pulse stretcher.
interface pulse_stretcher_if #(
  parameter int unsigned PW = 2
);
  logic          in;
  logic          out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  modport master (output in, input out, busy, pending, overflow);
  modport slave  (input in, output out, busy, pending, overflow);
endinterface

// File: rtl/pulse_stretcher_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module pulse_stretcher_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into HOLD-cycle high windows separated by GAP low cycles.
// Optional: define PULSE_STRETCHER_RETRIGGER_EN to let events during a window restart it.
module pulse_stretcher
  import debounce_pkg::*;
#(
  parameter int unsigned HOLD        = 4,
  parameter int unsigned GAP         = 2,
  parameter int unsigned MAX_PENDING = 3
) (
  input  logic             clock,
  input  logic             reset,
  pulse_stretcher_if.slave bus
);

  localparam int unsigned   CW       = cnt_width(HOLD, GAP);
  localparam int unsigned   PW       = pend_width(MAX_PENDING);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

  state_t        state_q, state_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          out_q, busy_q, overflow_q, overflow_d;
  logic          cnt_load, cnt_dec, cnt_zero_c;
  logic [CW-1:0] cnt_val;
  logic          enq, replay;

  pulse_stretcher_counter #(.W(CW)) u_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero_c)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    overflow_d = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = HOLD_LD;
    cnt_dec    = 1'b0;
    enq        = 1'b0;
    replay     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in) begin
          state_d  = ST_HIGH;
          cnt_load = 1'b1;
          cnt_val  = HOLD_LD;
        end
      end
      ST_HIGH: begin
        if (cnt_zero_c) begin
          state_d  = ST_GAP;
          cnt_load = 1'b1;
          cnt_val  = GAP_LD;
        end else begin
          cnt_dec = 1'b1;
        end
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (bus.in) begin
          state_d  = ST_HIGH;
          cnt_load = 1'b1;
          cnt_val  = HOLD_LD;
        end
`else
        enq = bus.in;
`endif
      end
      ST_GAP: begin
        enq = bus.in;
        if (cnt_zero_c) begin
          // Gap is over: a queued event or a coincident input opens the next window now.
          if ((pending_q != '0) || bus.in) begin
            state_d  = ST_HIGH;
            cnt_load = 1'b1;
            cnt_val  = HOLD_LD;
            replay   = (pending_q != '0);
            enq      = bus.in && (pending_q != '0);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (replay && !enq) begin
      pending_d = pending_q - PW'(1);
    end else if (enq && !replay) begin
      if (pending_q != PEND_MAX) begin
        pending_d = pending_q + PW'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      out_q      <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      out_q      <= (state_d == ST_HIGH);
      busy_q     <= (state_d != ST_IDLE);
      overflow_q <= overflow_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher; the reference tracks window start times and a pending count.
module tb_pulse_stretcher;

  localparam int unsigned HOLD = 4;
  localparam int unsigned GAP  = 2;
  localparam int unsigned MAXP = 3;
  localparam int unsigned PW   = $clog2(MAXP + 1);

  typedef struct packed {
    logic          out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  pulse_stretcher_if #(.PW(PW)) bus ();

  pulse_stretcher #(.HOLD(HOLD), .GAP(GAP), .MAX_PENDING(MAXP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #20 clock = ~clock;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   t      = 0;

  // Reference: a window opened at edge s is high after edges s..s+HOLD-1,
  // low for the next GAP edges, and the gap closes at edge s+HOLD+GAP.
  bit m_active  = 1'b0;
  int m_start   = 0;
  int m_pending = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (step %0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  task automatic model_step(input bit v);
    exp_t e;
    bit   ovf;
    int   el;
    ovf = 1'b0;
    if (!m_active) begin
      if (v) begin
        m_active = 1'b1;
        m_start  = t;
      end
    end else begin
      el = t - m_start;
      if (el == int'(HOLD + GAP)) begin
        if (m_pending > 0) begin
          m_start = t;
          if (!v) m_pending--;
        end else if (v) begin
          m_start = t;
        end else begin
          m_active = 1'b0;
        end
      end else if (v) begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (el <= int'(HOLD)) m_start = t;
        else if (m_pending < int'(MAXP)) m_pending++;
        else ovf = 1'b1;
`else
        if (m_pending < int'(MAXP)) m_pending++;
        else ovf = 1'b1;
`endif
      end
    end
    e.out      = m_active && ((t - m_start) < int'(HOLD));
    e.busy     = m_active;
    e.pending  = PW'(m_pending);
    e.overflow = ovf;
    sb.push_back(e);
    t++;
  endtask

  task automatic drive_cycle(input bit v);
    @(negedge clock);
    bus.in = v;
    model_step(v);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0);
  endtask

  // Asserts reset between edges and expects outputs to clear without a clock.
  task automatic do_reset();
    @(posedge clock);
    #5;
    reset = 1'b1;
    bus.in = 1'b0;
    #1;
    check("async_rst_out", int'(bus.out), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_pending", int'(bus.pending), 0);
    check("async_rst_overflow", int'(bus.overflow), 0);
    m_active  = 1'b0;
    m_pending = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  always @(posedge clock) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("out", int'(bus.out), int'(e.out));
      check("busy", int'(bus.busy), int'(e.busy));
      check("pending", int'(bus.pending), int'(e.pending));
      check("overflow", int'(bus.overflow), int'(e.overflow));
    end
  end

  initial begin
    bus.in = 1'b0;
    #1;
    reset = 1'b1;
    #2;
    check("reset_out", int'(bus.out), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_pending", int'(bus.pending), 0);
    check("reset_overflow", int'(bus.overflow), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Single pulse from idle.
    drive_cycle(1'b1);
    idle_cycles(11);

    // Two pulses two cycles apart.
    drive_cycle(1'b1); drive_cycle(1'b0); drive_cycle(1'b1);
    idle_cycles(20);

    // Five back-to-back pulses: saturate then overflow.
    for (int i = 0; i < 5; i++) drive_cycle(1'b1);
    idle_cycles(25);

    // Pulse on the last gap cycle with two queued.
    for (int i = 0; i < 3; i++) drive_cycle(1'b1);
    idle_cycles(3);
    drive_cycle(1'b1);
    idle_cycles(30);

    // Reset mid-window with two queued, then a fresh pulse.
    for (int i = 0; i < 3; i++) drive_cycle(1'b1);
    drive_cycle(1'b0);
    do_reset();
    drive_cycle(1'b1);
    idle_cycles(12);

    // Pulses three cycles apart (retrigger pattern when enabled).
    drive_cycle(1'b1); idle_cycles(2); drive_cycle(1'b1);
    idle_cycles(15);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive_cycle($urandom_range(0, 3) == 0);
      if ((i % 500) == 499) do_reset();
    end
    idle_cycles(40);

    @(posedge clock);
    #2;
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
